// File: rtl/fu_writeback_scheduler_pkg.sv
// Shared definitions for the EXE-stage multicycle writeback scheduler.
//   NUM_FU       number of multicycle functional units (bit i = unit i)
//   MAX_WAIT     denied cycles after which a finished unit jumps the queue
//   WAIT_W       width of the per-unit wait counter
//   fu_id_t      unit index names
//   sb_entry_t   one scoreboard entry: {valid, done, rd, fp}
//   ST_*         entry states, encoded as {valid, done}
//   src_match    does an ID source operand hit a scoreboard entry
package fu_writeback_scheduler_pkg;

  localparam int NUM_FU   = 7;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 3;

  typedef enum logic [2:0] {
    FU_MUL   = 3'd0,
    FU_DIV   = 3'd1,
    FU_FADD  = 3'd2,
    FU_FMUL  = 3'd3,
    FU_FDIV  = 3'd4,
    FU_FSQRT = 3'd5,
    FU_R4    = 3'd6
  } fu_id_t;

  typedef struct packed {
    logic       valid;
    logic       done;
    logic [4:0] rd;
    logic       fp;
  } sb_entry_t;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_PENDING   = 2'b10;
  localparam logic [1:0] ST_DONE_WAIT = 2'b11;

  // Integer x0 is hard-wired zero and never creates a dependency; FP f0 does.
  function automatic logic src_match(sb_entry_t e, logic [4:0] rs, logic rs_fp);
    return e.valid && (e.rd == rs) && (e.fp == rs_fp) && (rs_fp || (rs != 5'd0));
  endfunction

endpackage

// File: rtl/fu_age_arbiter.sv
// Single-grant arbiter for the EXE->MEM result path.
//   cand       units that are finished and hold a pending result
//   wait_cnt   consecutive denied cycles per unit (saturating)
//   advance    EXE/MEM register enabled; no grant without it
//   grant      one-hot winner, zero when nothing can move
//   grant_idx  binary index of grant, zero when grant is zero
// Starved candidates (wait_cnt >= MAX_WAIT) form a higher-priority pool;
// within a pool the lowest index wins.
module fu_age_arbiter
  import fu_writeback_scheduler_pkg::*;
#(
  parameter int N  = NUM_FU,
  parameter int MW = MAX_WAIT,
  parameter int WW = WAIT_W
) (
  input  logic [N-1:0]         cand,
  input  logic [N-1:0][WW-1:0] wait_cnt,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [2:0]           grant_idx
);

  logic [N-1:0] promoted;
  logic [N-1:0] pool;
  logic         found;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    promoted  = '0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      promoted[i] = cand[i] && (wait_cnt[i] >= WW'(MW));
    end
    pool = (|promoted) ? promoted : cand;
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (pool[i] && !found) begin
          grant[i]  = 1'b1;
          grant_idx = 3'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fu_writeback_scheduler.sv
// Writeback scheduler for the EXE-stage multicycle units.
//   clk, reset          clock, asynchronous active-high reset
//   issue_*             ID->EXE issue of a multicycle op (one-hot target unit)
//   rs*_id, rs*_fp_id   ID source operands for the RAW-busy check
//   fu_done             per-unit result-ready levels, held until granted
//   advance             EXE/MEM register enable
//   grant, grant_idx    unit whose result moves to MEM this cycle
//   result_valid        a result moves this cycle
//   fu_hold             finished units that must keep their result
//   fu_pending          scoreboard valid bits
//   issue_stall         issue target unit is still occupied
//   rd_busy             an ID source hits a pending destination
//   protocol_err        sticky: done without pending op, or non-one-hot issue
module fu_writeback_scheduler
  import fu_writeback_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [NUM_FU-1:0] issue_fu,
  input  logic [4:0]        issue_rd,
  input  logic              issue_fp,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic [4:0]        rs3_id,
  input  logic              rs1_fp_id,
  input  logic              rs2_fp_id,
  input  logic              rs3_fp_id,
  input  logic [NUM_FU-1:0] fu_done,
  input  logic              advance,
  output logic [NUM_FU-1:0] grant,
  output logic [2:0]        grant_idx,
  output logic              result_valid,
  output logic [NUM_FU-1:0] fu_hold,
  output logic [NUM_FU-1:0] fu_pending,
  output logic              issue_stall,
  output logic              rd_busy,
  output logic              protocol_err
);

  sb_entry_t                     entry_q [NUM_FU];
  sb_entry_t                     entry_d [NUM_FU];
  logic [NUM_FU-1:0][WAIT_W-1:0] wait_q, wait_d;
  logic                          protocol_err_q, protocol_err_d;
  logic [NUM_FU-1:0]             candidates;
  logic                          issue_onehot;
  logic                          issue_accept;

  always_comb begin
    fu_pending = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_pending[i] = entry_q[i].valid;
    end
  end

  assign candidates = fu_done & fu_pending;

  fu_age_arbiter #(
    .N  (NUM_FU),
    .MW (MAX_WAIT),
    .WW (WAIT_W)
  ) u_arb (
    .cand      (candidates),
    .wait_cnt  (wait_q),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign result_valid = |grant;
  assign fu_hold      = fu_done & ~grant;
  assign issue_onehot = $onehot(issue_fu);
  // A unit retiring this cycle frees its slot for a same-cycle issue.
  assign issue_stall  = issue_valid & |(issue_fu & fu_pending & ~grant);
  assign issue_accept = issue_valid & issue_onehot & ~issue_stall;
  assign protocol_err = protocol_err_q;

  // Entries being granted still count: the forwarding path only covers
  // them from the next cycle on.
  always_comb begin
    rd_busy = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      rd_busy = rd_busy
              | src_match(entry_q[i], rs1_id, rs1_fp_id)
              | src_match(entry_q[i], rs2_id, rs2_fp_id)
              | src_match(entry_q[i], rs3_id, rs3_fp_id);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      entry_d[i] = entry_q[i];
      case ({entry_q[i].valid, entry_q[i].done})
        ST_PENDING: begin
          if (grant[i])                   entry_d[i] = '0;
          else if (advance && fu_done[i]) entry_d[i].done = 1'b1;
        end
        ST_DONE_WAIT: begin
          if (grant[i]) entry_d[i] = '0;
        end
        default: entry_d[i] = '0;
      endcase
      // A same-cycle issue refills the slot, overriding the retirement.
      if (issue_accept && issue_fu[i]) begin
        entry_d[i] = '{valid: 1'b1, done: 1'b0, rd: issue_rd, fp: issue_fp};
      end

      if (candidates[i] && !grant[i]) begin
        wait_d[i] = (wait_q[i] >= WAIT_W'(MAX_WAIT)) ? WAIT_W'(MAX_WAIT)
                                                     : wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = '0;
      end
    end

    protocol_err_d = protocol_err_q
                   | (issue_valid & ~issue_onehot)
                   | (|(fu_done & ~fu_pending));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scoreboard array is reset on purpose; a stale valid bit
      // after reset would stall issue and raise false RAW hazards.
      for (int i = 0; i < NUM_FU; i++) begin
        entry_q[i] <= '0;
      end
      wait_q         <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        entry_q[i] <= entry_d[i];
      end
      wait_q         <= wait_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_fu_writeback_scheduler.sv
module tb_fu_writeback_scheduler;
  import fu_writeback_scheduler_pkg::*;

  localparam int N = NUM_FU;

  logic         clk;
  logic         reset;
  logic         issue_valid;
  logic [N-1:0] issue_fu;
  logic [4:0]   issue_rd;
  logic         issue_fp;
  logic [4:0]   rs1_id, rs2_id, rs3_id;
  logic         rs1_fp_id, rs2_fp_id, rs3_fp_id;
  logic [N-1:0] fu_done;
  logic         advance;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         result_valid;
  logic [N-1:0] fu_hold;
  logic [N-1:0] fu_pending;
  logic         issue_stall;
  logic         rd_busy;
  logic         protocol_err;

  int n_checks = 0;
  int n_pass   = 0;

  fu_writeback_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_fu     (issue_fu),
    .issue_rd     (issue_rd),
    .issue_fp     (issue_fp),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs3_id       (rs3_id),
    .rs1_fp_id    (rs1_fp_id),
    .rs2_fp_id    (rs2_fp_id),
    .rs3_fp_id    (rs3_fp_id),
    .fu_done      (fu_done),
    .advance      (advance),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .result_valid (result_valid),
    .fu_hold      (fu_hold),
    .fu_pending   (fu_pending),
    .issue_stall  (issue_stall),
    .rd_busy      (rd_busy),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-unit pending flag, destination, file, wait count.
  bit m_pend [N];
  int m_rd   [N];
  bit m_fp   [N];
  int m_wait [N];
  bit m_err;

  function automatic bit hit(int i, logic [4:0] rs, logic rs_fp);
    return m_pend[i] && (m_rd[i] == int'(rs)) && (m_fp[i] == rs_fp) && !(rs == 0 && !rs_fp);
  endfunction

  function automatic void model_comb(output logic [N-1:0] g, output logic [2:0] idx,
                                     output logic st, output logic busy);
    int pick;
    pick = -1;
    g    = '0;
    idx  = '0;
    if (advance) begin
      for (int i = N - 1; i >= 0; i--) if (fu_done[i] && m_pend[i]) pick = i;
      for (int i = N - 1; i >= 0; i--)
        if (fu_done[i] && m_pend[i] && m_wait[i] >= MAX_WAIT) pick = i;
      if (pick >= 0) begin
        g[pick] = 1'b1;
        idx     = 3'(pick);
      end
    end
    st = 1'b0;
    if (issue_valid)
      for (int i = 0; i < N; i++) if (issue_fu[i] && m_pend[i] && !g[i]) st = 1'b1;
    busy = 1'b0;
    for (int i = 0; i < N; i++)
      if (hit(i, rs1_id, rs1_fp_id) || hit(i, rs2_id, rs2_fp_id) || hit(i, rs3_id, rs3_fp_id))
        busy = 1'b1;
  endfunction

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] g;
    logic [2:0]   idx;
    logic         st, busy;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_rd[i] = 0; m_fp[i] = 0; m_wait[i] = 0;
      end
      m_err = 0;
    end else begin
      model_comb(g, idx, st, busy);
      for (int i = 0; i < N; i++) if (fu_done[i] && !m_pend[i]) m_err = 1;
      if (issue_valid && $countones(issue_fu) != 1) m_err = 1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_pend[i] = 0;
          m_wait[i] = 0;
        end else if (fu_done[i] && m_pend[i]) begin
          m_wait[i] = (m_wait[i] + 1 > MAX_WAIT) ? MAX_WAIT : m_wait[i] + 1;
        end else begin
          m_wait[i] = 0;
        end
      end
      if (issue_valid && $countones(issue_fu) == 1 && !st)
        for (int i = 0; i < N; i++)
          if (issue_fu[i]) begin
            m_pend[i] = 1; m_rd[i] = int'(issue_rd); m_fp[i] = issue_fp;
          end
    end
  end

  task automatic idle();
    issue_valid = 0; issue_fu = '0; issue_rd = '0; issue_fp = 0;
    rs1_id = '0; rs2_id = '0; rs3_id = '0;
    rs1_fp_id = 0; rs2_fp_id = 0; rs3_fp_id = 0;
    fu_done = '0; advance = 0;
  endtask

  task automatic issue(input fu_id_t f, input int rd, input logic fp);
    issue_valid = 1; issue_fu = N'(1) << f; issue_rd = 5'(rd); issue_fp = fp;
  endtask

  task automatic test_reset();
    @(negedge clk);
    fu_done = '1; advance = 1;
    #1;
    n_checks++; if (grant !== '0) $display("FAIL reset_grant got %b exp 0", grant); else n_pass++;
    n_checks++; if (fu_pending !== '0) $display("FAIL reset_pending got %b exp 0", fu_pending); else n_pass++;
    n_checks++; if (protocol_err !== 1'b0) $display("FAIL reset_err got %b exp 0", protocol_err); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", result_valid); else n_pass++;
    idle();
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    issue(FU_MUL, 5, 0); rs1_id = 5;
    #1;
    n_checks++; if (issue_stall !== 1'b0) $display("FAIL mul_stall got %b exp 0", issue_stall); else n_pass++;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL mul_busy_pre got %b exp 0", rd_busy); else n_pass++;
    @(negedge clk);
    issue_valid = 0;
    #1;
    n_checks++; if (fu_pending !== 7'b0000001) $display("FAIL mul_pending got %b exp 0000001", fu_pending); else n_pass++;
    n_checks++; if (rd_busy !== 1'b1) $display("FAIL mul_busy got %b exp 1", rd_busy); else n_pass++;
    rs1_fp_id = 1;
    #1;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL mul_busy_fp got %b exp 0", rd_busy); else n_pass++;
    rs1_fp_id = 0;
    @(negedge clk);
    @(negedge clk);
    fu_done = 7'b0000001; advance = 1;
    #1;
    n_checks++; if (grant !== 7'b0000001) $display("FAIL mul_grant got %b exp 0000001", grant); else n_pass++;
    n_checks++; if (grant_idx !== 3'd0) $display("FAIL mul_idx got %0d exp 0", grant_idx); else n_pass++;
    n_checks++; if (result_valid !== 1'b1) $display("FAIL mul_rvalid got %b exp 1", result_valid); else n_pass++;
    n_checks++; if (fu_hold !== '0) $display("FAIL mul_hold got %b exp 0", fu_hold); else n_pass++;
    n_checks++; if (rd_busy !== 1'b1) $display("FAIL mul_busy_grant got %b exp 1", rd_busy); else n_pass++;
    @(negedge clk);
    fu_done = '0; advance = 0;
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL mul_pending_clr got %b exp 0", fu_pending); else n_pass++;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL mul_busy_clr got %b exp 0", rd_busy); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_x0();
    issue(FU_MUL, 0, 0);
    @(negedge clk);
    issue(FU_FADD, 0, 1);
    @(negedge clk);
    idle(); rs1_id = 0; rs1_fp_id = 0;
    #1;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL x0_busy got %b exp 0", rd_busy); else n_pass++;
    rs2_id = 0; rs2_fp_id = 1;
    #1;
    n_checks++; if (rd_busy !== 1'b1) $display("FAIL f0_busy got %b exp 1", rd_busy); else n_pass++;
    idle(); fu_done = 7'b0000101; advance = 1;
    @(negedge clk);
    fu_done = 7'b0000100;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL x0_drain got %b exp 0", fu_pending); else n_pass++;
  endtask

  task automatic test_two_done();
    @(negedge clk);
    issue(FU_DIV, 7, 0);
    @(negedge clk);
    issue(FU_FDIV, 8, 1);
    @(negedge clk);
    idle(); fu_done = 7'b0010010; advance = 1;
    #1;
    n_checks++; if (grant !== 7'b0000010) $display("FAIL two_grant1 got %b exp 0000010", grant); else n_pass++;
    n_checks++; if (grant_idx !== 3'd1) $display("FAIL two_idx1 got %0d exp 1", grant_idx); else n_pass++;
    n_checks++; if (fu_hold !== 7'b0010000) $display("FAIL two_hold got %b exp 0010000", fu_hold); else n_pass++;
    @(negedge clk);
    fu_done = 7'b0010000;
    #1;
    n_checks++; if (grant !== 7'b0010000) $display("FAIL two_grant2 got %b exp 0010000", grant); else n_pass++;
    n_checks++; if (grant_idx !== 3'd4) $display("FAIL two_idx2 got %0d exp 4", grant_idx); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL two_drain got %b exp 0", fu_pending); else n_pass++;
  endtask

  task automatic test_starvation();
    @(negedge clk);
    issue(FU_FSQRT, 9, 1);
    @(negedge clk);
    issue(FU_MUL, 3, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      issue(FU_MUL, 3, 0); fu_done = 7'b0100001; advance = 1;
      #1;
      if (k < 4) begin
        n_checks++; if (grant !== 7'b0000001) $display("FAIL starve_mul%0d got %b exp 0000001", k, grant); else n_pass++;
        n_checks++; if (issue_stall !== 1'b0) $display("FAIL starve_stall%0d got %b exp 0", k, issue_stall); else n_pass++;
      end else begin
        n_checks++; if (grant !== 7'b0100000) $display("FAIL starve_promo got %b exp 0100000", grant); else n_pass++;
        n_checks++; if (grant_idx !== 3'd5) $display("FAIL starve_idx got %0d exp 5", grant_idx); else n_pass++;
        n_checks++; if (issue_stall !== 1'b1) $display("FAIL starve_stall got %b exp 1", issue_stall); else n_pass++;
      end
    end
    @(negedge clk);
    idle(); fu_done = 7'b0000001; advance = 1;
    #1;
    n_checks++; if (grant !== 7'b0000001) $display("FAIL starve_last got %b exp 0000001", grant); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL starve_drain got %b exp 0", fu_pending); else n_pass++;
  endtask

  task automatic test_advance_low();
    @(negedge clk);
    issue(FU_DIV, 10, 0);
    @(negedge clk);
    idle(); fu_done = 7'b0000010; advance = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (grant !== '0) $display("FAIL advlow_grant%0d got %b exp 0", k, grant); else n_pass++;
      n_checks++; if (fu_hold !== 7'b0000010) $display("FAIL advlow_hold%0d got %b exp 0000010", k, fu_hold); else n_pass++;
      @(negedge clk);
    end
    advance = 1;
    #1;
    n_checks++; if (grant !== 7'b0000010) $display("FAIL advlow_go got %b exp 0000010", grant); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL advlow_drain got %b exp 0", fu_pending); else n_pass++;
  endtask

  task automatic test_issue_stall();
    @(negedge clk);
    issue(FU_DIV, 11, 0);
    @(negedge clk);
    issue(FU_DIV, 12, 0);
    #1;
    n_checks++; if (issue_stall !== 1'b1) $display("FAIL stall_busy got %b exp 1", issue_stall); else n_pass++;
    @(negedge clk);
    idle(); rs1_id = 11;
    #1;
    n_checks++; if (fu_pending !== 7'b0000010) $display("FAIL stall_pend got %b exp 0000010", fu_pending); else n_pass++;
    n_checks++; if (rd_busy !== 1'b1) $display("FAIL stall_old_rd got %b exp 1", rd_busy); else n_pass++;
    rs1_id = 12;
    #1;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL stall_new_rd got %b exp 0", rd_busy); else n_pass++;
    issue(FU_DIV, 12, 0); fu_done = 7'b0000010; advance = 1;
    #1;
    n_checks++; if (issue_stall !== 1'b0) $display("FAIL refill_stall got %b exp 0", issue_stall); else n_pass++;
    n_checks++; if (grant !== 7'b0000010) $display("FAIL refill_grant got %b exp 0000010", grant); else n_pass++;
    @(negedge clk);
    idle(); rs1_id = 12;
    #1;
    n_checks++; if (fu_pending !== 7'b0000010) $display("FAIL refill_pend got %b exp 0000010", fu_pending); else n_pass++;
    n_checks++; if (rd_busy !== 1'b1) $display("FAIL refill_rd got %b exp 1", rd_busy); else n_pass++;
    rs1_id = 11;
    #1;
    n_checks++; if (rd_busy !== 1'b0) $display("FAIL refill_oldrd got %b exp 0", rd_busy); else n_pass++;
    fu_done = 7'b0000010; advance = 1;
    @(negedge clk);
    idle();
  endtask

  task automatic test_protocol_err();
    @(negedge clk);
    #1;
    n_checks++; if (protocol_err !== 1'b0) $display("FAIL perr_clean got %b exp 0", protocol_err); else n_pass++;
    fu_done = 7'b0001000;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (protocol_err !== 1'b1) $display("FAIL perr_set got %b exp 1", protocol_err); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (protocol_err !== 1'b1) $display("FAIL perr_sticky got %b exp 1", protocol_err); else n_pass++;
    issue_valid = 1; issue_fu = 7'b0000011; issue_rd = 1;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (fu_pending !== '0) $display("FAIL bad_issue got %b exp 0", fu_pending); else n_pass++;
    issue(FU_MUL, 4, 0);
    @(negedge clk);
    idle(); fu_done = 7'b0000001; advance = 1;
    #1;
    n_checks++; if (fu_pending !== 7'b0000001) $display("FAIL prst_pend got %b exp 0000001", fu_pending); else n_pass++;
    reset = 1;
    #1;
    n_checks++; if (protocol_err !== 1'b0) $display("FAIL arst_err got %b exp 0", protocol_err); else n_pass++;
    n_checks++; if (fu_pending !== '0) $display("FAIL arst_pend got %b exp 0", fu_pending); else n_pass++;
    n_checks++; if (grant !== '0) $display("FAIL arst_grant got %b exp 0", grant); else n_pass++;
    idle();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    logic [2:0]   ei;
    logic         es, eb;
    logic [31:0]  got, exp;
    reset = 1;
    #1;
    reset = 0;
    @(negedge clk);
    for (int k = 0; k < 400; k++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) issue_fu = N'($urandom_range(0, 127));
      else issue_fu = N'(1) << $urandom_range(0, N - 1);
      issue_rd  = 5'($urandom_range(0, 7));
      issue_fp  = 1'($urandom_range(0, 1));
      rs1_id    = 5'($urandom_range(0, 7)); rs1_fp_id = 1'($urandom_range(0, 1));
      rs2_id    = 5'($urandom_range(0, 7)); rs2_fp_id = 1'($urandom_range(0, 1));
      rs3_id    = 5'($urandom_range(0, 7)); rs3_fp_id = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        fu_done[i] = m_pend[i] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
      advance = ($urandom_range(0, 3) != 0);
      #1;
      model_comb(eg, ei, es, eb);
      exp = {7'd0, eg, ei, |eg, fu_done & ~eg, model_pend(), es, eb, m_err};
      got = {7'd0, grant, grant_idx, result_valid, fu_hold, fu_pending, issue_stall, rd_busy, protocol_err};
      n_checks++;
      if (got !== exp) $display("FAIL random_cycle%0d got %h exp %h", k, got, exp);
      else n_pass++;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    #1 reset = 1;
    test_reset();
    test_mul_basic();
    test_x0();
    test_two_done();
    test_starvation();
    test_advance_low();
    test_issue_stall();
    test_protocol_err();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
